// File: rtl/ctrl_pipe_unit_if.sv
// Camera capture handshake between the control unit and the camera block.
interface ctrl_pipe_unit_if;
  logic cam_req;
  logic cam_done;
  logic cam_err;

  modport master (output cam_req, output cam_err, input cam_done);
  modport slave  (input cam_req, input cam_err, output cam_done);
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: D-stage decode, E/M/W control registers and a sequencer
// that stalls D for multi-cycle MULT and camera (PIC) operations.
module ctrl_pipe_unit #(
    parameter int FUNCT_W     = 4,
    parameter int ALUC_W      = 4,
    parameter int MULT_LAT    = 3,
    parameter int PIC_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FUNCT_W-1:0] funct_d,
    input  logic               opcode_d,
    input  logic               valid_d,
    input  logic               hazard_d,
    input  logic               cond_e,
    ctrl_pipe_unit_if.master   cam,
    output logic [1:0]         reg_src_d,
    output logic [1:0]         imm_src_d,
    output logic               stall_d,
    output logic               illegal_d,
    output logic               alu_src_e,
    output logic [ALUC_W-1:0]  alu_ctrl_e,
    output logic               mem_to_reg_e,
    output logic               reg_write_e,
    output logic               plus_one_e,
    output logic               branch_e,
    output logic               branch_taken_e,
    output logic               reg_write_m,
    output logic               mem_write_m,
    output logic               mem_to_reg_m,
    output logic               pcsrc_m,
    output logic               reg_write_w,
    output logic               mem_to_reg_w,
    output logic               pcsrc_w
);

    localparam int CNT_MAX = (MULT_LAT > PIC_TIMEOUT) ? MULT_LAT : PIC_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [FUNCT_W-1:0] {
        F_ADD     = FUNCT_W'(0),
        F_SUB     = FUNCT_W'(1),
        F_MULT    = FUNCT_W'(2),
        F_LOAD    = FUNCT_W'(3),
        F_STR     = FUNCT_W'(4),
        F_SL      = FUNCT_W'(5),
        F_SR      = FUNCT_W'(6),
        F_B       = FUNCT_W'(7),
        F_PIC     = FUNCT_W'(8),
        F_AVG     = FUNCT_W'(9),
        F_STR_ONE = FUNCT_W'(10),
        F_THI     = FUNCT_W'(11)
    } funct_t;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD  = ALUC_W'(0),
        ALU_SUB  = ALUC_W'(1),
        ALU_MULT = ALUC_W'(2),
        ALU_BUF  = ALUC_W'(3),
        ALU_SL   = ALUC_W'(4),
        ALU_SR   = ALUC_W'(5),
        ALU_AV   = ALUC_W'(6),
        ALU_THI  = ALUC_W'(7)
    } aluc_t;

    typedef enum logic [1:0] {RUN, MUL, CAM} state_t;

    typedef struct packed {
        logic              aluSrc;
        logic [ALUC_W-1:0] aluCtrl;
        logic              memToReg;
        logic              regWrite;
        logic              memWrite;
        logic              plusOne;
        logic              branch;
    } ctrlE_t;

    localparam ctrlE_t BUBBLE = '{aluSrc: 1'b0, aluCtrl: ALU_BUF, memToReg: 1'b0,
                                  regWrite: 1'b0, memWrite: 1'b0, plusOne: 1'b0, branch: 1'b0};

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    ctrlE_t             dec, eReg;
    logic               illegalFunct, isMult, isPic, issue, timeoutHit;

    always_comb begin
        dec          = BUBBLE;
        dec.aluSrc   = opcode_d;
        dec.regWrite = 1'b1;
        reg_src_d    = 2'b00;
        imm_src_d    = 2'b00;
        isMult       = 1'b0;
        isPic        = 1'b0;
        illegalFunct = 1'b0;
        case (funct_t'(funct_d))
            F_ADD:  dec.aluCtrl = ALU_ADD;
            F_SUB:  dec.aluCtrl = ALU_SUB;
            F_MULT: begin dec.aluCtrl = ALU_MULT; isMult = 1'b1; end
            F_LOAD: begin dec.memToReg = 1'b1; imm_src_d = 2'b01; end
            F_STR: begin
                dec.regWrite = 1'b0;
                dec.memWrite = 1'b1;
                reg_src_d    = 2'b10;
                imm_src_d    = 2'b01;
            end
            F_SL:   dec.aluCtrl = ALU_SL;
            F_SR:   dec.aluCtrl = ALU_SR;
            F_B: begin
                dec.regWrite = 1'b0;
                dec.branch   = 1'b1;
                reg_src_d    = 2'b01;
                imm_src_d    = 2'b10;
            end
            F_PIC:  begin dec.regWrite = 1'b0; isPic = 1'b1; end
            F_AVG:  dec.aluCtrl = ALU_AV;
            F_STR_ONE: begin
                dec.regWrite = 1'b0;
                dec.memWrite = 1'b1;
                dec.plusOne  = 1'b1;
                reg_src_d    = 2'b10;
            end
            F_THI:  dec.aluCtrl = ALU_THI;
            default: illegalFunct = 1'b1;
        endcase
    end

    assign illegal_d      = valid_d & illegalFunct;
    assign branch_taken_e = eReg.branch & cond_e;
    assign issue          = valid_d & ~illegalFunct & ~stall_d & ~branch_taken_e;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        timeoutHit = 1'b0;
        case (state)
            RUN: begin
                if (issue && isMult && MULT_LAT > 1) begin
                    stateNext = MUL;
                    cntNext   = CNT_W'(MULT_LAT - 2);
                end else if (issue && isPic) begin
                    stateNext = CAM;
                    cntNext   = '0;
                end
            end
            MUL: begin
                if (cnt == '0) stateNext = RUN;
                else           cntNext   = cnt - 1'b1;
            end
            CAM: begin
                cntNext = cnt + 1'b1;
                // A done pulse on the final timeout cycle still counts as success.
                if (cam.cam_done) begin
                    stateNext = RUN;
                end else if (cnt == CNT_W'(PIC_TIMEOUT - 1)) begin
                    stateNext  = RUN;
                    timeoutHit = 1'b1;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    always_comb begin
        stall_d     = hazard_d | (state != RUN);
        cam.cam_req = (state == CAM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eReg         <= BUBBLE;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            pcsrc_m      <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            pcsrc_w      <= 1'b0;
            cam.cam_err  <= 1'b0;
        end else begin
            // MULT sits in E for its whole latency while M is fed bubbles.
            if (state != MUL) eReg <= issue ? dec : BUBBLE;
            if (state == MUL) begin
                reg_write_m  <= 1'b0;
                mem_write_m  <= 1'b0;
                mem_to_reg_m <= 1'b0;
                pcsrc_m      <= 1'b0;
            end else begin
                reg_write_m  <= eReg.regWrite;
                mem_write_m  <= eReg.memWrite;
                mem_to_reg_m <= eReg.memToReg;
                pcsrc_m      <= branch_taken_e;
            end
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            pcsrc_w      <= pcsrc_m;
            cam.cam_err  <= timeoutHit;
        end
    end

    assign alu_src_e    = eReg.aluSrc;
    assign alu_ctrl_e   = eReg.aluCtrl;
    assign mem_to_reg_e = eReg.memToReg;
    assign reg_write_e  = eReg.regWrite;
    assign plus_one_e   = eReg.plusOne;
    assign branch_e     = eReg.branch;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit with MULT_LAT=3 and PIC_TIMEOUT=8.
module tb_ctrl_pipe_unit;

    localparam int FADD = 0, FSUB = 1, FMULT = 2, FLOAD = 3, FSTR = 4, FB = 7, FPIC = 8;

    logic       clk = 1'b0;
    logic       rstN;
    logic [3:0] functD;
    logic       opcodeD, validD, hazardD, condE;
    logic [1:0] regSrcD, immSrcD;
    logic       stallD, illegalD;
    logic       aluSrcE, memToRegE, regWriteE, plusOneE, branchE, branchTakenE;
    logic [3:0] aluCtrlE;
    logic       regWriteM, memWriteM, memToRegM, pcsrcM;
    logic       regWriteW, memToRegW, pcsrcW;

    int errors = 0;
    int checks = 0;

    ctrl_pipe_unit_if camIf ();

    ctrl_pipe_unit #(
        .FUNCT_W(4), .ALUC_W(4), .MULT_LAT(3), .PIC_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rstN), .funct_d(functD), .opcode_d(opcodeD),
        .valid_d(validD), .hazard_d(hazardD), .cond_e(condE), .cam(camIf.master),
        .reg_src_d(regSrcD), .imm_src_d(immSrcD), .stall_d(stallD), .illegal_d(illegalD),
        .alu_src_e(aluSrcE), .alu_ctrl_e(aluCtrlE), .mem_to_reg_e(memToRegE),
        .reg_write_e(regWriteE), .plus_one_e(plusOneE), .branch_e(branchE),
        .branch_taken_e(branchTakenE), .reg_write_m(regWriteM), .mem_write_m(memWriteM),
        .mem_to_reg_m(memToRegM), .pcsrc_m(pcsrcM), .reg_write_w(regWriteW),
        .mem_to_reg_w(memToRegW), .pcsrc_w(pcsrcW)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setD(input int f, input logic op, input logic v);
        functD  = 4'(f);
        opcodeD = op;
        validD  = v;
    endtask

    initial begin
        rstN = 1'b0; hazardD = 1'b0; condE = 1'b0; camIf.cam_done = 1'b0;
        setD(FADD, 1'b0, 1'b0);
        tick(); tick();
        chk("rst alu_ctrl_e", aluCtrlE, 3);
        chk("rst reg_write_e", regWriteE, 0);
        chk("rst reg_write_w", regWriteW, 0);
        chk("rst cam_req", camIf.cam_req, 0);
        chk("rst cam_err", camIf.cam_err, 0);
        chk("rst stall_d", stallD, 0);
        rstN = 1'b1;

        // ADD, SUB, LOAD back to back
        setD(FADD, 1'b0, 1'b1); tick();
        chk("add alu_ctrl_e", aluCtrlE, 0);
        chk("add reg_write_e", regWriteE, 1);
        setD(FSUB, 1'b1, 1'b1); tick();
        chk("sub alu_ctrl_e", aluCtrlE, 1);
        chk("sub alu_src_e", aluSrcE, 1);
        setD(FLOAD, 1'b1, 1'b1); tick();
        chk("load alu_ctrl_e", aluCtrlE, 3);
        chk("load mem_to_reg_e", memToRegE, 1);
        chk("add reg_write_w", regWriteW, 1);
        chk("add mem_to_reg_w", memToRegW, 0);
        setD(FADD, 1'b0, 1'b0); tick();
        chk("sub reg_write_w", regWriteW, 1);
        tick();
        chk("load mem_to_reg_w", memToRegW, 1);
        chk("load reg_write_w", regWriteW, 1);
        chk("idle reg_write_e", regWriteE, 0);

        // external hazard
        setD(FADD, 1'b0, 1'b1); hazardD = 1'b1; #1;
        chk("hazard stall_d", stallD, 1);
        tick();
        chk("hazard bubble reg_write_e", regWriteE, 0);
        hazardD = 1'b0; setD(FADD, 1'b0, 1'b0);

        // MULT, latency 3
        setD(FMULT, 1'b0, 1'b1); #1;
        chk("mult issue stall_d", stallD, 0);
        tick();
        chk("mult c1 alu_ctrl_e", aluCtrlE, 2);
        chk("mult c1 stall_d", stallD, 1);
        setD(FADD, 1'b0, 1'b1); tick();
        chk("mult c2 alu_ctrl_e", aluCtrlE, 2);
        chk("mult c2 stall_d", stallD, 1);
        chk("mult c2 reg_write_m", regWriteM, 0);
        tick();
        chk("mult c3 alu_ctrl_e", aluCtrlE, 2);
        chk("mult c3 stall_d", stallD, 0);
        chk("mult c3 reg_write_m", regWriteM, 0);
        tick();
        chk("post-mult add alu_ctrl_e", aluCtrlE, 0);
        chk("mult reg_write_m", regWriteM, 1);
        setD(FADD, 1'b0, 1'b0);

        // PIC with cam_done in the fifth request cycle
        setD(FPIC, 1'b0, 1'b1); tick();
        chk("pic c1 cam_req", camIf.cam_req, 1);
        chk("pic c1 stall_d", stallD, 1);
        chk("pic reg_write_e", regWriteE, 0);
        chk("pic alu_ctrl_e", aluCtrlE, 3);
        setD(FADD, 1'b0, 1'b0); tick();
        chk("pic c2 cam_req", camIf.cam_req, 1);
        chk("pic reg_write_m", regWriteM, 0);
        tick();
        chk("pic c3 cam_req", camIf.cam_req, 1);
        chk("pic reg_write_w", regWriteW, 0);
        tick();
        chk("pic c4 cam_req", camIf.cam_req, 1);
        tick();
        chk("pic c5 cam_req", camIf.cam_req, 1);
        camIf.cam_done = 1'b1; tick(); camIf.cam_done = 1'b0;
        chk("pic done cam_req", camIf.cam_req, 0);
        chk("pic done stall_d", stallD, 0);
        chk("pic done cam_err", camIf.cam_err, 0);
        tick();
        chk("pic done cam_err later", camIf.cam_err, 0);

        // PIC timeout after 8 cycles
        setD(FPIC, 1'b0, 1'b1); tick();
        setD(FADD, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("timeout wait cam_req", camIf.cam_req, 1);
            chk("timeout wait cam_err", camIf.cam_err, 0);
        end
        setD(FADD, 1'b0, 1'b1); tick();
        chk("timeout cam_err", camIf.cam_err, 1);
        chk("timeout cam_req", camIf.cam_req, 0);
        chk("timeout stall_d", stallD, 0);
        chk("timeout e bubble", regWriteE, 0);
        tick();
        chk("timeout cam_err pulse end", camIf.cam_err, 0);
        chk("after timeout add alu_ctrl_e", aluCtrlE, 0);
        chk("after timeout add reg_write_e", regWriteE, 1);
        setD(FADD, 1'b0, 1'b0);

        // taken branch flushes a MULT in D
        setD(FB, 1'b0, 1'b1); tick();
        chk("b branch_e", branchE, 1);
        chk("b reg_write_e", regWriteE, 0);
        condE = 1'b1; setD(FMULT, 1'b0, 1'b1); #1;
        chk("branch_taken_e", branchTakenE, 1);
        tick();
        condE = 1'b0; setD(FADD, 1'b0, 1'b0);
        chk("flush branch_e", branchE, 0);
        chk("flush alu_ctrl_e", aluCtrlE, 3);
        chk("flush no mul stall", stallD, 0);
        chk("flush pcsrc_m", pcsrcM, 1);
        tick();
        chk("flush pcsrc_w", pcsrcW, 1);
        chk("flush pcsrc_m clear", pcsrcM, 0);

        // illegal funct, decode selects, store path
        setD(13, 1'b0, 1'b1); #1;
        chk("illegal_d", illegalD, 1);
        tick();
        chk("illegal reg_write_e", regWriteE, 0);
        chk("illegal alu_ctrl_e", aluCtrlE, 3);
        chk("illegal stall_d", stallD, 0);
        setD(13, 1'b0, 1'b0); #1;
        chk("illegal invalid illegal_d", illegalD, 0);
        setD(FB, 1'b0, 1'b0); #1;
        chk("b reg_src_d", regSrcD, 1);
        chk("b imm_src_d", immSrcD, 2);
        setD(FSTR, 1'b0, 1'b1); #1;
        chk("str reg_src_d", regSrcD, 2);
        chk("str imm_src_d", immSrcD, 1);
        tick(); setD(FADD, 1'b0, 1'b0); tick();
        chk("str mem_write_m", memWriteM, 1);
        chk("str reg_write_m", regWriteM, 0);

        // reset during CAM
        setD(FPIC, 1'b0, 1'b1); tick();
        setD(FADD, 1'b0, 1'b0); tick();
        chk("cam before reset cam_req", camIf.cam_req, 1);
        rstN = 1'b0; tick();
        chk("reset cam_req", camIf.cam_req, 0);
        chk("reset cam_err", camIf.cam_err, 0);
        chk("reset stall_d", stallD, 0);
        rstN = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("post reset cam_err", camIf.cam_err, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
